// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared types and constants for the byte-serial RAM bus responder.
//   Contents:
//     addr_t / byte_t          bus address and data types
//     IO_BASE_ADDR             default start of the I/O window
//     IO_OFF_DATA / _HALT      register offsets inside the I/O window
//     RW_READ / RW_WRITE       encodings of ram_rw_sel
//     acc_e / decode_access()  classification of one bus access
// ----------------------------------------------------------------------------
package mem_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [7:0]  byte_t;

    localparam addr_t IO_BASE_ADDR = 32'h0003_0000;
    localparam addr_t IO_OFF_DATA  = 32'd0;
    localparam addr_t IO_OFF_HALT  = 32'd4;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // What a single bus cycle does, independent of rdy.
    typedef enum logic [2:0] {
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_RX_RD,      // read of the RX data port
        ACC_STAT_RD,    // read of the TX drained flag
        ACC_TX_WR,      // push into the TX FIFO
        ACC_HALT_WR,    // set the halt flag
        ACC_IO_NOP_RD,  // unmapped I/O offset, reads 0
        ACC_IO_NOP_WR   // unmapped I/O offset, write dropped
    } acc_e;

    // Anything at or above io_base is I/O; the RAM never sees those addresses.
    function automatic acc_e decode_access(input addr_t addr, input logic rw_sel,
                                           input addr_t io_base);
        addr_t off;
        off = addr - io_base;
        if (addr < io_base)
            return (rw_sel == RW_WRITE) ? ACC_RAM_WR : ACC_RAM_RD;
        if (off == IO_OFF_DATA)
            return (rw_sel == RW_WRITE) ? ACC_TX_WR : ACC_RX_RD;
        if (off == IO_OFF_HALT)
            return (rw_sel == RW_WRITE) ? ACC_HALT_WR : ACC_STAT_RD;
        return (rw_sel == RW_WRITE) ? ACC_IO_NOP_WR : ACC_IO_NOP_RD;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//   Byte-serial RAM bus between the memory controller (master) and the
//   responder (slave).
//     ram_rw_sel   master->slave  0 = read, 1 = write
//     ram_addr     master->slave  byte address
//     ram_wr_byte  master->slave  write data
//     ram_rd_byte  slave->master  registered read data, 1-cycle latency
//     io_full      slave->master  TX almost full, used by the master as stall
//   Handshake: there is no per-access valid; every rising clk edge with rdy=1
//   performs the access currently on the bus. io_full is the only flow
//   control and is raised one entry early so the access already issued when
//   the master sees it still fits.
// ----------------------------------------------------------------------------
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic  ram_rw_sel;
    addr_t ram_addr;
    byte_t ram_wr_byte;
    byte_t ram_rd_byte;
    logic  io_full;

    modport master (output ram_rw_sel, ram_addr, ram_wr_byte,
                    input  ram_rd_byte, io_full);
    modport slave  (input  ram_rw_sel, ram_addr, ram_wr_byte,
                    output ram_rd_byte, io_full);
endinterface

// File: rtl/mem_responder_byte_fifo.sv
// ----------------------------------------------------------------------------
// mem_responder_byte_fifo
//   Small synchronous FIFO for the TX byte stream.
//     clk, rst_n    clock, asynchronous active-low reset
//     push, din     write request and data; accepted if not full or if a pop
//                   happens in the same cycle
//     pop           read request; ignored when empty
//     dout          head entry, combinational from storage
//     empty, count  occupancy
//     almost_full   registered (count >= DEPTH-1), reflects the post-edge count
// ----------------------------------------------------------------------------
module mem_responder_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             full, do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign do_push = push && (!full || do_pop);
    assign dout    = storage[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (!do_push && do_pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            storage[wr_ptr] <= din;
    end

    // Pointers are PTR_W wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count       <= count_next;
            almost_full <= (count_next >= CNT_W'(DEPTH - 1));
        end
    end
endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Target of the byte-serial RAM bus. Low addresses hit a single-port byte
//   RAM; addresses at or above IO_BASE form an I/O window:
//     +0 write: push TX FIFO (overflow is sticky)   +0 read: RX byte, pops host
//     +4 write: set halted                          +4 read: {7'b0, TX drained}
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     rdy           global ready; low freezes all bus-side state
//     bus           slave side of mem_responder_if (addr/rw/data, io_full)
//     tx_valid/tx_data/tx_ready   TX FIFO head, popped when valid && ready
//     rx_valid/rx_data/rx_pop     host RX byte and its consume pulse
//     halted, tx_overflow         sticky status flags
// ----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int    ADDR_W   = 17,
    parameter addr_t IO_BASE  = IO_BASE_ADDR,
    parameter int    TX_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    mem_responder_if.slave       bus,
    output logic                 tx_valid,
    output byte_t                tx_data,
    input  logic                 tx_ready,
    input  logic                 rx_valid,
    input  byte_t                rx_data,
    output logic                 rx_pop,
    output logic                 halted,
    output logic                 tx_overflow
);
    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    byte_t             mem [2**ADDR_W];
    byte_t             rd_q;
    acc_e              acc;
    logic [ADDR_W-1:0] ram_idx;
    logic [CNT_W-1:0]  tx_count;
    logic              tx_empty, tx_full, tx_push, tx_pop, tx_almost_full;

    always_comb acc = decode_access(bus.ram_addr, bus.ram_rw_sel, IO_BASE);

    // Address bits above ADDR_W alias onto the RAM.
    assign ram_idx  = bus.ram_addr[ADDR_W-1:0];
    assign tx_valid = !tx_empty;
    assign tx_full  = (tx_count == CNT_W'(TX_DEPTH));
    assign tx_push  = rdy && (acc == ACC_TX_WR);
    // The consumer side runs even while the bus is frozen.
    assign tx_pop   = tx_valid && tx_ready;
    // Combinational so the host retires its byte on the same edge that
    // captures it into ram_rd_byte.
    assign rx_pop   = rst_n && rdy && (acc == ACC_RX_RD) && rx_valid;

    assign bus.ram_rd_byte = rd_q;
    assign bus.io_full     = tx_almost_full;

    mem_responder_byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (tx_push),
        .din         (bus.ram_wr_byte),
        .pop         (tx_pop),
        .dout        (tx_data),
        .empty       (tx_empty),
        .count       (tx_count),
        .almost_full (tx_almost_full)
    );

    always_ff @(posedge clk) begin
        if (rdy && (acc == ACC_RAM_WR))
            mem[ram_idx] <= bus.ram_wr_byte;
    end

    // Read data register; writes and unmapped reads return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rdy) begin
            case (acc)
                ACC_RAM_RD:  rd_q <= mem[ram_idx];
                ACC_RX_RD:   rd_q <= rx_valid ? rx_data : 8'h00;
                ACC_STAT_RD: rd_q <= {7'b0, ~tx_valid};
                default:     rd_q <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted      <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (rdy && (acc == ACC_HALT_WR))
                halted <= 1'b1;
            if (tx_push && tx_full && !tx_pop)
                tx_overflow <= 1'b1;
        end
    end
endmodule
